// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM transfer sequencer.
//   bk_state_e   : sequencer states
//   bk_req_e     : kind of transfer latched when a request is accepted
//   SECTOR_SHIFT : log2 of the hps_io sector size in bytes
package bk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        REQ,
        ACK,
        DONE
    } bk_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LOAD,
        REQ_SAVE
    } bk_req_e;

    localparam int unsigned SECTOR_SHIFT = 9;

endpackage

// File: rtl/bk_ram_ctrl_if.sv
// Sector request/acknowledge handshake toward hps_io.
//   sd_lba : sector number (upper bits zero)
//   sd_rd  : sector read request
//   sd_wr  : sector write request
//   sd_ack : hps_io sector acknowledge
// master = the backup-RAM sequencer, slave = hps_io.
interface bk_ram_ctrl_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/bk_edge_det.sv
// Rise/fall detector for a level input.
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   din     : level input
//   rise    : din went 0 -> 1 since the previous cycle
//   fall    : din went 1 -> 0 since the previous cycle
// The history register always samples din, so after reset it already holds the
// current level and no phantom edge follows; edges are masked while in reset.
module bk_edge_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    always_ff @(posedge clk_sys) begin
        din_q <= din;
    end

    assign rise = ~reset &  din & ~din_q;
    assign fall = ~reset & ~din &  din_q;

endmodule

// File: rtl/bk_ram_ctrl.sv
// Backup-RAM (BSRAM) load/save sequencer between on-chip BSRAM and the save image.
//   clk_sys, reset        : clock, synchronous active-high reset
//   ioctl_download        : ROM download in progress (fall -> auto load)
//   img_mounted/readonly/size_nz : save image mount strobe and attributes
//   ram_mask              : BSRAM byte mask (0 = no BSRAM)
//   bk_load, bk_save      : OSD load/save request levels
//   osd_status, autosave_en : OSD open level, autosave-on-open enable
//   bsram_wr              : core write into BSRAM
//   sd                    : sector handshake to hps_io (master side)
//   bk_ena                : backup enabled
//   bk_loading            : load in progress (extends core reset)
//   busy                  : transfer active
//   bk_error              : sticky handshake timeout flag
module bk_ram_ctrl
    import bk_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000,
    parameter int unsigned LBA_BITS    = 15
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          img_mounted,
    input  logic          img_readonly,
    input  logic          img_size_nz,
    input  logic [23:0]   ram_mask,
    input  logic          bk_load,
    input  logic          bk_save,
    input  logic          osd_status,
    input  logic          autosave_en,
    input  logic          bsram_wr,
    bk_ram_ctrl_if.master sd,
    output logic          bk_ena,
    output logic          bk_loading,
    output logic          busy,
    output logic          bk_error
);

    bk_state_e           state_q, state_d;
    bk_req_e             kind_q, kind_d;
    logic [LBA_BITS-1:0] lba_q, lba_d;
    logic [23:0]         wd_q, wd_d;
    logic bk_ena_q, bk_ena_d, loading_q, loading_d, busy_q, busy_d;
    logic error_q, error_d, dirty_q, dirty_d, pend_q, pend_d;

    logic dl_rise, dl_fall, load_rise, save_rise, osd_rise, ack_rise, ack_fall;
    logic load_fall, save_fall, osd_fall;
    logic unused_edges;

    bk_edge_det u_dl_edge (.clk_sys(clk_sys), .reset(reset), .din(ioctl_download),
                           .rise(dl_rise), .fall(dl_fall));
    bk_edge_det u_load_edge (.clk_sys(clk_sys), .reset(reset), .din(bk_load),
                             .rise(load_rise), .fall(load_fall));
    bk_edge_det u_save_edge (.clk_sys(clk_sys), .reset(reset), .din(bk_save),
                             .rise(save_rise), .fall(save_fall));
    bk_edge_det u_osd_edge (.clk_sys(clk_sys), .reset(reset), .din(osd_status),
                            .rise(osd_rise), .fall(osd_fall));
    bk_edge_det u_ack_edge (.clk_sys(clk_sys), .reset(reset), .din(sd.sd_ack),
                            .rise(ack_rise), .fall(ack_fall));

    assign unused_edges = ^{load_fall, save_fall, osd_fall};

    logic                load_edge, save_edge, timeout, abort_xfer;
    logic [LBA_BITS-1:0] last_lba;

    assign load_edge = dl_fall | load_rise;
    assign save_edge = save_rise | (osd_rise & autosave_en & dirty_q);
    assign last_lba  = LBA_BITS'(ram_mask[23:SECTOR_SHIFT]);
    // Watchdog counts cycles spent in the current REQ/ACK wait, starting at 0.
    assign timeout   = (wd_q >= ACK_TIMEOUT - 24'd1);

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        lba_d      = lba_q;
        wd_d       = wd_q;
        bk_ena_d   = bk_ena_q;
        loading_d  = loading_q;
        busy_d     = busy_q;
        error_d    = error_q;
        dirty_d    = dirty_q;
        pend_d     = pend_q;
        abort_xfer = 1'b0;

        if (dl_rise) bk_ena_d = 1'b0;
        if (ioctl_download & img_mounted & img_size_nz & ~img_readonly) bk_ena_d = |ram_mask;

        case (state_q)
            IDLE: begin
                if (bk_ena_q) begin
                    if (load_edge) begin
                        kind_d  = REQ_LOAD;
                        state_d = START;
                        // A save that loses to a load runs right after it.
                        if (save_edge) pend_d = 1'b1;
                    end else if (save_edge | pend_q) begin
                        kind_d  = REQ_SAVE;
                        state_d = START;
                    end
                end
            end
            START: begin
                lba_d     = '0;
                loading_d = (kind_q == REQ_LOAD);
                busy_d    = 1'b1;
                error_d   = 1'b0;
                wd_d      = '0;
                if (kind_q == REQ_SAVE) begin
                    dirty_d = 1'b0;
                    pend_d  = 1'b0;
                end
                state_d = REQ;
            end
            REQ: begin
                wd_d = wd_q + 24'd1;
                if (ack_rise) begin
                    wd_d    = '0;
                    state_d = ACK;
                end else if (timeout) begin
                    abort_xfer = 1'b1;
                end
            end
            ACK: begin
                wd_d = wd_q + 24'd1;
                if (ack_fall) begin
                    if (lba_q >= last_lba) begin
                        state_d = DONE;
                    end else begin
                        lba_d   = lba_q + LBA_BITS'(1);
                        wd_d    = '0;
                        state_d = REQ;
                    end
                end else if (timeout) begin
                    abort_xfer = 1'b1;
                end
            end
            DONE: begin
                loading_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_xfer) begin
            state_d   = IDLE;
            loading_d = 1'b0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            // The image was not fully written, so BSRAM is still unsaved.
            if (kind_q == REQ_SAVE) dirty_d = 1'b1;
        end

        if ((state_q != IDLE) && save_edge) pend_d = 1'b1;
        // Writes during a save re-dirty, since the sector may already be stored.
        if (bsram_wr && !loading_q) dirty_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            kind_q    <= REQ_NONE;
            lba_q     <= '0;
            wd_q      <= '0;
            bk_ena_q  <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            dirty_q   <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            lba_q     <= lba_d;
            wd_q      <= wd_d;
            bk_ena_q  <= bk_ena_d;
            loading_q <= loading_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            dirty_q   <= dirty_d;
            pend_q    <= pend_d;
        end
    end

    assign sd.sd_lba  = 32'(lba_q);
    assign sd.sd_rd   = (state_q == REQ) &  loading_q;
    assign sd.sd_wr   = (state_q == REQ) & ~loading_q;
    assign bk_ena     = bk_ena_q;
    assign bk_loading = loading_q;
    assign busy       = busy_q;
    assign bk_error   = error_q;

endmodule

// File: tb/tb_bk_ram_ctrl.sv
module tb_bk_ram_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset, ioctl_download, img_mounted, img_readonly, img_size_nz;
    logic [23:0] ram_mask;
    logic        bk_load, bk_save, osd_status, autosave_en, bsram_wr;
    logic        bk_ena, bk_loading, busy, bk_error;

    bk_ram_ctrl_if sd ();

    bk_ram_ctrl #(
        .ACK_TIMEOUT(24'd100),
        .LBA_BITS   (15)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size_nz   (img_size_nz),
        .ram_mask      (ram_mask),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .osd_status    (osd_status),
        .autosave_en   (autosave_en),
        .bsram_wr      (bsram_wr),
        .sd            (sd.master),
        .bk_ena        (bk_ena),
        .bk_loading    (bk_loading),
        .busy          (busy),
        .bk_error      (bk_error)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int          tests  = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];              // {is_write, lba} per expected sector request
    bit          ack_en    = 1'b1;
    logic [31:0] stall_lba = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference model: a transfer touches sectors 0 .. ram_mask[23:9] in order.
    task automatic push_xfer(input bit wr, input logic [23:0] mask);
        for (int i = 0; i <= int'(mask[23:9]); i++) exp_q.push_back({wr, 32'(i)});
    endtask

    task automatic pulse(input int which);
        case (which)
            0: bk_load = 1'b1;
            1: bk_save = 1'b1;
            2: osd_status = 1'b1;
            default: bsram_wr = 1'b1;
        endcase
        step();
        bk_load = 1'b0; bk_save = 1'b0; osd_status = 1'b0; bsram_wr = 1'b0;
        step();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            step();
            n++;
        end
        chk({name, "_finished"}, 64'(n >= 5000), 0);
        chk({name, "_loading"}, bk_loading, 0);
        chk({name, "_error"}, bk_error, 0);
    endtask

    task automatic idle_window(input string name);
        bit fired = 1'b0;
        repeat (20) begin
            step();
            if (busy || sd.sd_rd || sd.sd_wr) fired = 1'b1;
        end
        chk(name, fired, 0);
    endtask

    // hps_io model + monitor: pops the expected sector on every new request.
    initial begin
        logic [32:0] e;
        logic [31:0] lba;
        int unsigned d, h;
        sd.sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en && !reset && (sd.sd_rd || sd.sd_wr)) begin
                lba = sd.sd_lba;
                chk("rd_wr_exclusive", 64'(sd.sd_rd & sd.sd_wr), 0);
                chk("loading_matches_rd", bk_loading, sd.sd_rd);
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", {sd.sd_wr, lba}, 64'h1_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sector_request", {sd.sd_wr, lba}, e);
                end
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk_sys);
                sd.sd_ack = 1'b1;
                h = (lba == stall_lba) ? 10 : $urandom_range(1, 3);
                repeat (h) @(negedge clk_sys);
                sd.sd_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [23:0] m;
        bit          wr;
        int          n;

        reset = 1'b1; ioctl_download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size_nz = 1'b1; ram_mask = 24'h0; bk_load = 1'b0; bk_save = 1'b0;
        osd_status = 1'b0; autosave_en = 1'b0; bsram_wr = 1'b0;
        repeat (3) step();
        chk("rst_sd_rd", sd.sd_rd, 0);
        chk("rst_sd_wr", sd.sd_wr, 0);
        chk("rst_sd_lba", sd.sd_lba, 0);
        chk("rst_bk_ena", bk_ena, 0);
        chk("rst_loading", bk_loading, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", bk_error, 0);
        reset = 1'b0;
        step();

        // Enable backup via a mount during download, then auto-load on download end.
        ram_mask = 24'h1FFF;
        ioctl_download = 1'b1; step();
        img_mounted = 1'b1; step();
        img_mounted = 1'b0; step();
        chk("bk_ena_set", bk_ena, 1);
        push_xfer(1'b0, 24'h1FFF);
        ioctl_download = 1'b0;
        step();
        chk("latency_start", sd.sd_rd, 0);
        step();
        chk("latency_rd", sd.sd_rd, 1);
        chk("latency_loading", bk_loading, 1);
        wait_done("autoload16");
        // A finished load leaves BSRAM clean, so autosave must not fire.
        autosave_en = 1'b1;
        pulse(2);
        idle_window("no_autosave_after_load");
        autosave_en = 1'b0;

        // Randomized manual loads/saves of random sizes.
        for (int it = 0; it < 6; it++) begin
            m  = (it == 0) ? 24'h7FF : {15'($urandom_range(0, 5)), 9'h1FF};
            wr = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ram_mask = m;
            push_xfer(wr, m);
            pulse(wr ? 1 : 0);
            wait_done(wr ? "rand_save" : "rand_load");
        end

        // Simultaneous load and save: load first, pending save follows.
        ram_mask = {15'($urandom_range(0, 3)), 9'h1FF};
        push_xfer(1'b0, ram_mask);
        push_xfer(1'b1, ram_mask);
        bk_load = 1'b1; bk_save = 1'b1;
        step();
        bk_load = 1'b0; bk_save = 1'b0;
        step();
        wait_done("load_then_save");

        // Write mid-save re-dirties; autosave on OSD open then saves again.
        ram_mask = 24'h7FF;
        push_xfer(1'b1, 24'h7FF);
        pulse(1);
        n = 0;
        while (!(sd.sd_wr && sd.sd_lba == 2) && n < 200) begin step(); n++; end
        chk("reach_lba2", 64'(n >= 200), 0);
        bsram_wr = 1'b1; step(); bsram_wr = 1'b0;
        wait_done("save_with_write");
        autosave_en = 1'b1;
        push_xfer(1'b1, 24'h7FF);
        pulse(2);
        wait_done("autosave");
        pulse(2);
        idle_window("autosave_clean");
        pulse(3);
        autosave_en = 1'b0;
        pulse(2);
        idle_window("autosave_disabled");

        // Clean save, then a save that never gets acknowledged.
        push_xfer(1'b1, 24'h7FF);
        pulse(1);
        wait_done("clean_save");
        ack_en = 1'b0;
        bk_save = 1'b1; step(); bk_save = 1'b0;
        n = 0;
        while (!sd.sd_wr && n < 20) begin step(); n++; end
        n = 0;
        while (sd.sd_wr && n < 1000) begin step(); n++; end
        chk("timeout_wr_cycles", n, 100);
        chk("timeout_error", bk_error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_loading", bk_loading, 0);
        ack_en = 1'b1;
        // Aborted save restores dirty, so an autosave must run and clear the error.
        autosave_en = 1'b1;
        push_xfer(1'b1, 24'h7FF);
        pulse(2);
        wait_done("autosave_after_timeout");
        autosave_en = 1'b0;

        // Reset while waiting for the ack fall of sector 5.
        ram_mask = 24'h1FFF;
        for (int i = 0; i <= 5; i++) exp_q.push_back({1'b0, 32'(i)});
        stall_lba = 32'd5;
        pulse(0);
        n = 0;
        while (!(sd.sd_ack && !sd.sd_rd && sd.sd_lba == 5) && n < 500) begin step(); n++; end
        chk("reach_ack_lba5", 64'(n >= 500), 0);
        reset = 1'b1;
        step();
        chk("midrst_sd_rd", sd.sd_rd, 0);
        chk("midrst_sd_wr", sd.sd_wr, 0);
        chk("midrst_sd_lba", sd.sd_lba, 0);
        chk("midrst_loading", bk_loading, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_bk_ena", bk_ena, 0);
        reset = 1'b0;
        stall_lba = 32'hFFFF_FFFF;
        repeat (12) step();
        chk("midrst_queue_empty", exp_q.size(), 0);

        // Read-only image: backup stays disabled and requests are ignored.
        ioctl_download = 1'b1; img_readonly = 1'b1; step();
        img_mounted = 1'b1; step();
        img_mounted = 1'b0; step();
        ioctl_download = 1'b0;
        repeat (5) step();
        chk("readonly_bk_ena", bk_ena, 0);
        chk("readonly_no_load", busy, 0);
        pulse(1);
        idle_window("readonly_save_ignored");
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/bk_ram_ctrl.md
Name: bk_ram_ctrl

Overview:
Sequences backup-RAM (BSRAM) transfers between the on-chip BSRAM and the mounted save image. Transfers run through the sector-based sd_lba/sd_rd/sd_wr/sd_ack handshake of hps_io. Handles manual load/save requests from OSD status bits, an automatic load after ROM download, and an optional autosave when the OSD opens while BSRAM is dirty. Sits beside the bsram dpram in the top level and drives hps_io's SD request lines and the core reset extension (bk_loading).

Parameters:
ACK_TIMEOUT, 24'd10_000_000, clk_sys cycles allowed between any sd_rd/sd_wr assertion and the sd_ack rise, and between the sd_ack rise and the sd_ack fall.
LBA_BITS, 15, width of the internal sector counter (covers ram_mask[23:9]).

Ports:
clk_sys  in  1  system clock; every register samples on the rising edge
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  ROM download in progress
img_mounted  in  1  save image mount strobe
img_readonly  in  1  mounted image is read-only
img_size_nz  in  1  mounted image size is non-zero
ram_mask  in  24  BSRAM byte mask from ROM detect (0 = no BSRAM)
bk_load  in  1  OSD load request level (edge-detected)
bk_save  in  1  OSD save request level (edge-detected)
osd_status  in  1  OSD open level (edge-detected)
autosave_en  in  1  autosave on OSD-open enable
bsram_wr  in  1  core write strobe into BSRAM (~CE_N & ~WE_N)
sd_ack  in  1  hps_io sector acknowledge
sd_lba  out  32  sector number; upper bits are zero
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  backup enabled (drives the OSD menu enables)
bk_loading  out  1  load in progress (ORed into core reset)
busy  out  1  a transfer is active
bk_error  out  1  sticky timeout flag; cleared by the next accepted request

Behaviour:
- Reset: every output is 0. State = IDLE. dirty = 0. pending_save = 0. All edge-detector history regs load their current input values, so no spurious edge follows reset.
- bk_ena:
  - Cleared on the ioctl_download rising edge.
  - Set to |ram_mask when ioctl_download & img_mounted & img_size_nz & ~img_readonly are all true in the same cycle.
- Request sources, sampled only in IDLE and only when bk_ena = 1:
  - (a) ioctl_download falling edge -> load.
  - (b) bk_load rising edge -> load.
  - (c) bk_save rising edge -> save.
  - (d) osd_status rising edge & autosave_en & dirty -> save.
  - (e) pending_save -> save.
- Priority when several are true in one cycle: a > b > c > d > e. Any save request that loses to a load sets pending_save.
- A bk_save or autosave edge that arrives while busy sets pending_save. A load edge that arrives while busy is dropped.
- FSM states:
  - IDLE: waits for a request.
  - START: sd_lba <= 0; bk_loading <= is_load; busy <= 1; bk_error <= 0; a save also clears dirty and pending_save. Goes to REQ.
  - REQ: drives sd_rd = bk_loading or sd_wr = ~bk_loading. On the sd_ack rise: drop both requests in the same cycle and go to ACK.
  - ACK: waits for the sd_ack fall. If sd_lba[LBA_BITS-1:0] >= ram_mask[23:9], go to DONE. Otherwise sd_lba + 1 and back to REQ (request re-asserts the next cycle).
  - DONE: bk_loading <= 0, busy <= 0, back to IDLE.
- Request-to-request gap is 1 cycle minimum; latency from request edge to the first sd_rd/sd_wr is 2 cycles.
- Timeout: a watchdog counter reloads on each entry to REQ or ACK. If it reaches ACK_TIMEOUT, the block drops sd_rd/sd_wr, sets bk_error, clears bk_loading/busy and returns to IDLE. dirty is restored to 1 if the aborted transfer was a save.
- dirty:
  - Set by bsram_wr whenever bk_loading = 0, including during a save, so a write mid-save re-dirties.
  - A load completing does not set dirty.
- A ram_mask of 1KB gives 2 sectors (LBA 0..1). Sector count = ram_mask[23:9] + 1.
- sd_ack held high at entry to REQ counts as a rise only after it is first observed low (edge-based).
- Reset mid-transfer: returns to the reset values immediately, and the hps_io request is dropped.

Decomposition:
- Package bk_pkg: state enum (IDLE, START, REQ, ACK, DONE); request-kind enum (REQ_NONE, REQ_LOAD, REQ_SAVE); SECTOR_SHIFT = 9.
- One sub-module, bk_edge_det (rise/fall detector with a reset-primed history reg), is instantiated once per level input.

Test Plan:
- ram_mask = 24'h1FFF, bk_ena set, ioctl_download falls -> 16 sd_rd pulses with LBA 0..15; bk_loading is high throughout and low 1 cycle after the 16th ack falls; dirty = 0.
- bk_save edge with ram_mask = 24'h7FF -> sd_wr at LBA 0..3, no sd_rd; busy drops after the 4th ack; bk_error = 0.
- bk_load and bk_save rise in the same cycle -> load runs first, then a save runs immediately after DONE (pending_save).
- bsram_wr during the save's LBA 2, then osd_status rises with autosave_en = 1 -> a second full save; with autosave_en = 0 -> no transfer.
- sd_ack never rises, ACK_TIMEOUT overridden to 100 -> sd_wr is high for 100 cycles then drops; bk_error = 1; busy = 0; dirty = 1.
- reset asserted in ACK at LBA 5 -> next cycle sd_rd = sd_wr = 0, sd_lba = 0, bk_loading = 0, busy = 0; img_readonly = 1 at mount -> bk_ena stays 0 and bk_save is ignored.
